// File: rtl/lamp_mon_pkg.sv
// Shared definitions for the lamp conflict monitor.
// Contents:
//   FLAG_W          width of the sticky fault flag vector
//   PH_*            2-bit phase encoding used by the per-road trackers
//   F_*             bit positions inside fault_flags
//   legal_step()    true when a phase change follows GRN->YEL->RED->GRN
package lamp_mon_pkg;

  localparam int FLAG_W = 6;

  localparam logic [1:0] PH_UNK = 2'd0;
  localparam logic [1:0] PH_RED = 2'd1;
  localparam logic [1:0] PH_YEL = 2'd2;
  localparam logic [1:0] PH_GRN = 2'd3;

  localparam int F_PAT_A    = 0;
  localparam int F_PAT_B    = 1;
  localparam int F_CONFLICT = 2;
  localparam int F_TRANS    = 3;
  localparam int F_YELLOW   = 4;
  localparam int F_DWELL    = 5;

  function automatic logic legal_step(input logic [1:0] from_ph, input logic [1:0] to_ph);
    return ((from_ph == PH_GRN) && (to_ph == PH_YEL)) ||
           ((from_ph == PH_YEL) && (to_ph == PH_RED)) ||
           ((from_ph == PH_RED) && (to_ph == PH_GRN));
  endfunction

endpackage

// File: rtl/lamp_conflict_monitor_if.sv
// Lamp bus between the intersection controller side and the safety monitor.
// Signals:
//   red_a/yel_a/grn_a, red_b/yel_b/grn_b  lamp lines of road A and road B
//   fault_clr                              one-cycle request to clear latched faults
//   fault_flags[5:0]                       sticky fault flags (see lamp_mon_pkg F_*)
//   fault                                  OR of fault_flags, registered
//   flash_on                               flashing-yellow drive for the lamp-driver board
// Modports:
//   master  drives lamps and fault_clr, observes the monitor outputs
//   slave   the monitor itself
// Handshake: there is no valid/ready pair on this bus. Lamps are level signals
// sampled every clock; fault_clr is a single-cycle level, honoured only on a
// cycle where both sampled patterns are valid and not in conflict.
interface lamp_conflict_monitor_if;
  import lamp_mon_pkg::*;

  logic              red_a;
  logic              yel_a;
  logic              grn_a;
  logic              red_b;
  logic              yel_b;
  logic              grn_b;
  logic              fault_clr;
  logic [FLAG_W-1:0] fault_flags;
  logic              fault;
  logic              flash_on;

  modport master (
    output red_a, yel_a, grn_a, red_b, yel_b, grn_b, fault_clr,
    input  fault_flags, fault, flash_on
  );

  modport slave (
    input  red_a, yel_a, grn_a, red_b, yel_b, grn_b, fault_clr,
    output fault_flags, fault, flash_on
  );

endinterface

// File: rtl/lamp_phase_tracker.sv
// Per-road phase tracker. Follows the registered lamp pattern of one road,
// counts how long the current phase has been shown and reports rule breaks.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   en                checks and tracking enabled (lamp sample holds a real value)
//   red, yel, grn     registered lamps of this road
//   clr               qualified clear: return to UNK / count 0
//   phase             current tracked phase (PH_*), doubles as state debug view
//   pattern_err       not exactly one lamp lit
//   trans_err         phase change out of GRN->YEL->RED->GRN order
//   yel_err           yellow too short before red, or lit MAX_YELLOW cycles
//   dwell_err         green or red lit MAX_DWELL cycles (0 disables)
//   non_red           yellow or green lit (used for the conflict check)
// The *_err outputs are combinational; the top registers them as flags.
module lamp_phase_tracker
  import lamp_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_YELLOW = 8,
  parameter int MAX_DWELL  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       red,
  input  logic       yel,
  input  logic       grn,
  input  logic       clr,
  output logic [1:0] phase,
  output logic       pattern_err,
  output logic       trans_err,
  output logic       yel_err,
  output logic       dwell_err,
  output logic       non_red
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_Y_C = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(MAX_DWELL);
  localparam logic             DWELL_ON = (MAX_DWELL != 0);

  logic [1:0]       phase_q;
  logic [1:0]       seen_ph;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             valid;
  logic             changed;

  // Decode one-hot lamp pattern; anything else maps to PH_UNK (= invalid).
  always_comb begin
    seen_ph = PH_UNK;
    case ({grn, yel, red})
      3'b001:  seen_ph = PH_RED;
      3'b010:  seen_ph = PH_YEL;
      3'b100:  seen_ph = PH_GRN;
      default: seen_ph = PH_UNK;
    endcase
  end

  assign valid   = (seen_ph != PH_UNK);
  assign changed = valid && (seen_ph != phase_q);

  always_comb begin
    count_nxt = count_q;
    if (changed) begin
      count_nxt = CNT_ONE;
    end else if (valid && (count_q != CNT_MAX)) begin
      count_nxt = count_q + CNT_ONE;
    end
  end

  assign pattern_err = en && !valid;
  assign trans_err   = en && changed && (phase_q != PH_UNK) && !legal_step(phase_q, seen_ph);
  // Timing limits are judged on the count including the current sample, so a
  // yellow lit for MAX_YELLOW samples is flagged on the edge that sees it.
  assign yel_err     = en && valid &&
                       (((phase_q == PH_YEL) && (seen_ph == PH_RED) && (count_q < MIN_Y_C)) ||
                        ((seen_ph == PH_YEL) && (count_nxt == MAX_Y_C)));
  assign dwell_err   = en && valid && DWELL_ON &&
                       ((seen_ph == PH_RED) || (seen_ph == PH_GRN)) && (count_nxt == DWELL_C);
  assign non_red     = yel | grn;
  assign phase       = phase_q;

  // Invalid patterns hold phase and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_UNK;
      count_q <= '0;
    end else if (clr) begin
      phase_q <= PH_UNK;
      count_q <= '0;
    end else if (en && valid) begin
      phase_q <= seen_ph;
      count_q <= count_nxt;
    end
  end

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Independent safety monitor for the two-road intersection lamp outputs.
// Registers the six lamp lines once, tracks each road's phase, latches sticky
// fault flags and drives a flashing-yellow override request.
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous, active-low
//   bus      lamp_conflict_monitor_if.slave:
//              lamps (in), fault_clr (in), fault_flags/fault/flash_on (out)
module lamp_conflict_monitor
  import lamp_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_YELLOW = 8,
  parameter int MAX_DWELL  = 200,
  parameter int FLASH_HALF = 4
) (
  input logic                    clk,
  input logic                    reset,
  lamp_conflict_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  logic [2:0]        lamp_a_q;   // {grn, yel, red}
  logic [2:0]        lamp_b_q;
  logic              primed_q;   // lamp regs hold a real sample, not reset zeros
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_set;
  logic [FLAG_W-1:0] flags_nxt;
  logic              fault_q;
  logic [CNT_W-1:0]  flash_cnt_q;
  logic              flash_q;

  logic [1:0] phase_a, phase_b;
  logic       pat_a, pat_b, trans_a, trans_b, yel_a, yel_b, dwell_a, dwell_b;
  logic       non_red_a, non_red_b;
  logic       conflict;
  logic       clr_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lamp_a_q <= '0;
      lamp_b_q <= '0;
      primed_q <= 1'b0;
    end else begin
      lamp_a_q <= {bus.grn_a, bus.yel_a, bus.red_a};
      lamp_b_q <= {bus.grn_b, bus.yel_b, bus.red_b};
      primed_q <= 1'b1;
    end
  end

  lamp_phase_tracker #(
    .CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .MAX_DWELL(MAX_DWELL)
  ) u_trk_a (
    .clk(clk), .reset(reset), .en(primed_q),
    .red(lamp_a_q[0]), .yel(lamp_a_q[1]), .grn(lamp_a_q[2]), .clr(clr_ok),
    .phase(phase_a), .pattern_err(pat_a), .trans_err(trans_a),
    .yel_err(yel_a), .dwell_err(dwell_a), .non_red(non_red_a)
  );

  lamp_phase_tracker #(
    .CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .MAX_DWELL(MAX_DWELL)
  ) u_trk_b (
    .clk(clk), .reset(reset), .en(primed_q),
    .red(lamp_b_q[0]), .yel(lamp_b_q[1]), .grn(lamp_b_q[2]), .clr(clr_ok),
    .phase(phase_b), .pattern_err(pat_b), .trans_err(trans_b),
    .yel_err(yel_b), .dwell_err(dwell_b), .non_red(non_red_b)
  );

  // Conflict looks at raw lamp bits, so it fires even on invalid patterns.
  assign conflict = primed_q && non_red_a && non_red_b;

  // A clear is only trusted while the lamps show a sane, non-conflicting picture.
  assign clr_ok = bus.fault_clr && primed_q && !pat_a && !pat_b && !conflict;

  always_comb begin
    flags_set             = '0;
    flags_set[F_PAT_A]    = pat_a;
    flags_set[F_PAT_B]    = pat_b;
    flags_set[F_CONFLICT] = conflict;
    flags_set[F_TRANS]    = trans_a | trans_b;
    flags_set[F_YELLOW]   = yel_a | yel_b;
    flags_set[F_DWELL]    = dwell_a | dwell_b;
    // Set wins over a same-cycle clear.
    flags_nxt = (clr_ok ? '0 : flags_q) | flags_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      fault_q <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      fault_q <= |flags_nxt;
    end
  end

  // Flash runs off the registered fault, so the first rise of flash_on lands
  // FLASH_HALF edges after fault rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else if (!fault_q) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else if (flash_cnt_q == FLASH_LAST) begin
      flash_cnt_q <= '0;
      flash_q     <= ~flash_q;
    end else begin
      flash_cnt_q <= flash_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fault_flags = flags_q;
  assign bus.fault       = fault_q;
  assign bus.flash_on    = flash_q;

endmodule
